// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the line burst responder: responder FSM state type,
// default burst geometry, derived line width and the line-offset width that
// is stripped from request addresses.
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

   localparam int DEF_BEAT_WIDTH = 64;
   localparam int DEF_NUM_BEATS  = 4;
   localparam int LINE_WIDTH     = DEF_BEAT_WIDTH * DEF_NUM_BEATS;
   localparam int OFFSET_BITS    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/beat_assembler.sv
// ---------------------------------------------------------------------------
// beat_assembler
// One line-wide buffer that either serialises a line into beats (load, then
// shift right one beat at a time) or assembles a line from beats (write one
// beat into the slot selected by beat_idx).
// Ports:
//   clk, rst    clock, synchronous active-high reset (buffer clears to 0)
//   load_line   capture line_in (highest priority after reset)
//   line_in     full line to load
//   shift_beat  shift the buffer right by one beat, zero filling the top
//   write_beat  write beat_in into slot beat_idx
//   beat_idx    slot index for write_beat
//   beat_in     beat data for write_beat
//   line_out    whole buffer
//   beat_out    lowest beat of the buffer (next beat to send)
// ---------------------------------------------------------------------------
module beat_assembler #(
   parameter int BEAT_WIDTH = 64,
   parameter int NUM_BEATS  = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load_line,
   input  logic [BEAT_WIDTH*NUM_BEATS-1:0]      line_in,
   input  logic                                 shift_beat,
   input  logic                                 write_beat,
   input  logic [$clog2(NUM_BEATS)-1:0]         beat_idx,
   input  logic [BEAT_WIDTH-1:0]                beat_in,
   output logic [BEAT_WIDTH*NUM_BEATS-1:0]      line_out,
   output logic [BEAT_WIDTH-1:0]                beat_out
);

   logic [BEAT_WIDTH*NUM_BEATS-1:0] line_buf;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_buf <= '0;
      end else if (load_line) begin
         line_buf <= line_in;
      end else if (shift_beat) begin
         line_buf <= line_buf >> BEAT_WIDTH;
      end else if (write_beat) begin
         line_buf[int'(beat_idx)*BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
      end
   end

   assign line_out = line_buf;
   assign beat_out = line_buf[BEAT_WIDTH-1:0];

endmodule

// File: rtl/line_burst_responder.sv
// ---------------------------------------------------------------------------
// line_burst_responder
// Accepts one whole-line read or write from the L2 line interface and turns
// it into a NUM_BEATS-beat burst on the memory port, then returns a single
// cycle line_resp. One transaction outstanding at a time.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   line_addr    line request address (offset bits ignored)
//   line_read    line read request, held until line_resp
//   line_write   line write request, held until line_resp (wins over read)
//   line_wdata   write line, beat 0 in the low bits
//   line_rdata   last completed read line
//   line_resp    one-cycle completion pulse
//   burst_addr   line-aligned burst address
//   burst_read   burst read request
//   burst_write  burst write request
//   burst_wdata  current write beat
//   burst_rdata  read beat, valid with burst_resp
//   burst_resp   beat strobe, one beat per high cycle
// ---------------------------------------------------------------------------
module line_burst_responder
   import cache_pkg::*;
#(
   parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
   parameter int NUM_BEATS  = DEF_NUM_BEATS
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [31:0]                       line_addr,
   input  logic                              line_read,
   input  logic                              line_write,
   input  logic [BEAT_WIDTH*NUM_BEATS-1:0]   line_wdata,
   output logic [BEAT_WIDTH*NUM_BEATS-1:0]   line_rdata,
   output logic                              line_resp,
   output logic [31:0]                       burst_addr,
   output logic                              burst_read,
   output logic                              burst_write,
   output logic [BEAT_WIDTH-1:0]             burst_wdata,
   input  logic [BEAT_WIDTH-1:0]             burst_rdata,
   input  logic                              burst_resp
);

   localparam int CNT_W = $clog2(NUM_BEATS);

   state_t                              state;
   logic [CNT_W-1:0]                    cnt;
   logic                                last_beat;
   logic                                wr_load;
   logic                                wr_shift;
   logic                                rd_write;
   logic [BEAT_WIDTH*NUM_BEATS-1:0]     wr_line_unused;
   logic [BEAT_WIDTH-1:0]               rd_beat_unused;
   logic [OFFSET_BITS-1:0]              addr_offset_unused;

   // Offset bits never reach the memory side; the burst is always line aligned.
   assign addr_offset_unused = line_addr[OFFSET_BITS-1:0];

   assign last_beat = burst_resp && (cnt == CNT_W'(NUM_BEATS - 1));
   assign wr_load   = (state == ST_IDLE)  && line_write;
   assign wr_shift  = (state == ST_WRITE) && burst_resp;
   assign rd_write  = (state == ST_READ)  && burst_resp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         line_resp   <= 1'b0;
         burst_read  <= 1'b0;
         burst_write <= 1'b0;
         burst_addr  <= '0;
      end else begin
         line_resp <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Write has priority if the requester ever raises both.
               if (line_write) begin
                  burst_addr  <= {line_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  burst_write <= 1'b1;
                  state       <= ST_WRITE;
               end else if (line_read) begin
                  burst_addr  <= {line_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  burst_read  <= 1'b1;
                  state       <= ST_READ;
               end
            end
            ST_READ: begin
               if (last_beat) begin
                  cnt        <= '0;
                  burst_read <= 1'b0;
                  line_resp  <= 1'b1;
                  state      <= ST_DONE;
               end else if (burst_resp) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WRITE: begin
               if (last_beat) begin
                  cnt         <= '0;
                  burst_write <= 1'b0;
                  line_resp   <= 1'b1;
                  state       <= ST_DONE;
               end else if (burst_resp) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // The request is still high here; returning to IDLE without
               // looking at it avoids accepting the finished request again.
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Write path: serialise the latched line, lowest beat first.
   beat_assembler #(
      .BEAT_WIDTH (BEAT_WIDTH),
      .NUM_BEATS  (NUM_BEATS)
   ) u_wr_shift (
      .clk        (clk),
      .rst        (rst),
      .load_line  (wr_load),
      .line_in    (line_wdata),
      .shift_beat (wr_shift),
      .write_beat (1'b0),
      .beat_idx   ('0),
      .beat_in    ('0),
      .line_out   (wr_line_unused),
      .beat_out   (burst_wdata)
   );

   // Read path: place each returning beat into its slot; holds until the next read.
   beat_assembler #(
      .BEAT_WIDTH (BEAT_WIDTH),
      .NUM_BEATS  (NUM_BEATS)
   ) u_rd_buf (
      .clk        (clk),
      .rst        (rst),
      .load_line  (1'b0),
      .line_in    ('0),
      .shift_beat (1'b0),
      .write_beat (rd_write),
      .beat_idx   (cnt),
      .beat_in    (burst_rdata),
      .line_out   (line_rdata),
      .beat_out   (rd_beat_unused)
   );

endmodule

// File: tb/tb_line_burst_responder.sv
// ---------------------------------------------------------------------------
// tb_line_burst_responder
// Directed bench for line_burst_responder: reads, stalled writes,
// back-to-back transactions, reset mid-burst, stray beat strobes, the
// read/write collision and a requester that holds its request too long.
// ---------------------------------------------------------------------------
module tb_line_burst_responder;
   import cache_pkg::*;

   localparam int BW = DEF_BEAT_WIDTH;
   localparam int LW = LINE_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   line_addr;
   logic          line_read;
   logic          line_write;
   logic [LW-1:0] line_wdata;
   logic [LW-1:0] line_rdata;
   logic          line_resp;
   logic [31:0]   burst_addr;
   logic          burst_read;
   logic          burst_write;
   logic [BW-1:0] burst_wdata;
   logic [BW-1:0] burst_rdata;
   logic          burst_resp;

   int checks = 0;
   int errors = 0;

   line_burst_responder #(
      .BEAT_WIDTH (BW),
      .NUM_BEATS  (DEF_NUM_BEATS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .line_addr   (line_addr),
      .line_read   (line_read),
      .line_write  (line_write),
      .line_wdata  (line_wdata),
      .line_rdata  (line_rdata),
      .line_resp   (line_resp),
      .burst_addr  (burst_addr),
      .burst_read  (burst_read),
      .burst_write (burst_write),
      .burst_wdata (burst_wdata),
      .burst_rdata (burst_rdata),
      .burst_resp  (burst_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [BW-1:0] rd1 [4];
   logic [BW-1:0] rd2 [4];
   logic [BW-1:0] wb  [4];
   logic [BW-1:0] eb  [4];
   logic [BW-1:0] wexp [7];
   logic          wpat [7];
   logic [LW-1:0] rd1_line;
   logic [LW-1:0] rd2_line;

   initial begin
      rd1  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      rd2  = '{64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0002,
               64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0004};
      wb   = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
               64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
      eb   = '{64'hE0E0_E0E0_E0E0_E0E0, 64'hE1E1_E1E1_E1E1_E1E1,
               64'hE2E2_E2E2_E2E2_E2E2, 64'hE3E3_E3E3_E3E3_E3E3};
      // Beat strobe pattern 1,0,1,1,0,0,1; burst_wdata seen before each edge.
      wpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      wexp = '{wb[0], wb[1], wb[1], wb[2], wb[3], wb[3], wb[3]};
      rd1_line = {rd1[3], rd1[2], rd1[1], rd1[0]};
      rd2_line = {rd2[3], rd2[2], rd2[1], rd2[0]};

      rst         = 1'b1;
      line_addr   = '0;
      line_read   = 1'b0;
      line_write  = 1'b0;
      line_wdata  = '0;
      burst_rdata = '0;
      burst_resp  = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_line_resp",   LW'(line_resp),   '0);
      chk("rst_burst_read",  LW'(burst_read),  '0);
      chk("rst_burst_write", LW'(burst_write), '0);
      chk("rst_burst_addr",  LW'(burst_addr),  '0);
      chk("rst_burst_wdata", LW'(burst_wdata), '0);
      chk("rst_line_rdata",  line_rdata,       '0);
      chk("rst_state",       LW'(dut.state),   LW'(ST_IDLE));
      rst = 1'b0;

      // Test 1: read, memory answers 2 cycles after burst_read rises
      line_addr = 32'h0000_1234;
      line_read = 1'b1;
      tick();                                   // accept edge (cycle 0)
      chk("t1_burst_read",  LW'(burst_read), LW'(1'b1));
      chk("t1_burst_addr",  LW'(burst_addr), LW'(32'h0000_1220));
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = rd1[i];
         chk("t1_no_early_resp", LW'(line_resp),  '0);
         chk("t1_read_held",     LW'(burst_read), LW'(1'b1));
         tick();
      end
      burst_resp  = 1'b0;
      burst_rdata = '0;
      chk("t1_line_resp",   LW'(line_resp),  LW'(1'b1));
      chk("t1_read_drop",   LW'(burst_read), '0);
      chk("t1_line_rdata",  line_rdata,      rd1_line);
      tick();                                   // DONE -> IDLE, request still held
      chk("t1_resp_single", LW'(line_resp),  '0);
      chk("t1_idle_gap",    LW'(dut.state),  LW'(ST_IDLE));
      chk("t1_no_reaccept", LW'(burst_read), '0);

      // Tests 2/3: write presented the cycle after line_resp, with stalls
      line_read  = 1'b0;
      line_write = 1'b1;
      line_addr  = 32'h0000_ABCD;
      line_wdata = {wb[3], wb[2], wb[1], wb[0]};
      tick();
      chk("t2_burst_write", LW'(burst_write), LW'(1'b1));
      chk("t2_burst_addr",  LW'(burst_addr),  LW'(32'h0000_ABC0));
      chk("t2_state",       LW'(dut.state),   LW'(ST_WRITE));
      line_wdata = '1;                          // must be ignored mid-transaction
      line_addr  = 32'hFFFF_FFFF;
      for (int i = 0; i < 7; i++) begin
         chk("t2_burst_wdata",  LW'(burst_wdata), LW'(wexp[i]));
         chk("t2_write_held",   LW'(burst_write), LW'(1'b1));
         chk("t2_no_early_resp", LW'(line_resp),  '0);
         burst_resp = wpat[i];
         tick();
      end
      burst_resp = 1'b0;
      chk("t2_line_resp",   LW'(line_resp),   LW'(1'b1));
      chk("t2_write_drop",  LW'(burst_write), '0);
      chk("t2_addr_const",  LW'(burst_addr),  LW'(32'h0000_ABC0));
      chk("t3_rdata_keep",  line_rdata,       rd1_line);
      tick();
      chk("t2_resp_single", LW'(line_resp),   '0);
      chk("t2_idle",        LW'(dut.state),   LW'(ST_IDLE));
      line_write = 1'b0;

      // Test 5: stray strobe in IDLE, then read+write together
      burst_resp  = 1'b1;
      burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      burst_resp  = 1'b0;
      burst_rdata = '0;
      chk("t5_stray_state", LW'(dut.state),   LW'(ST_IDLE));
      chk("t5_stray_read",  LW'(burst_read),  '0);
      chk("t5_stray_write", LW'(burst_write), '0);
      chk("t5_stray_rdata", line_rdata,       rd1_line);
      line_read  = 1'b1;
      line_write = 1'b1;
      line_addr  = 32'h2000_0047;
      line_wdata = {eb[3], eb[2], eb[1], eb[0]};
      tick();
      chk("t5_both_write", LW'(burst_write), LW'(1'b1));
      chk("t5_both_read",  LW'(burst_read),  '0);
      chk("t5_both_addr",  LW'(burst_addr),  LW'(32'h2000_0040));
      for (int i = 0; i < 4; i++) begin
         chk("t5_burst_wdata", LW'(burst_wdata), LW'(eb[i]));
         burst_resp = 1'b1;
         tick();
      end
      burst_resp = 1'b0;
      chk("t5_line_resp", LW'(line_resp), LW'(1'b1));
      tick();
      line_read  = 1'b0;
      line_write = 1'b0;

      // Test 4: reset after beat 2 of a read
      line_read = 1'b1;
      line_addr = 32'h0000_5678;
      tick();
      chk("t4_burst_addr", LW'(burst_addr), LW'(32'h0000_5660));
      burst_resp  = 1'b1;
      burst_rdata = 64'h5555_5555_5555_5555;
      tick();
      burst_rdata = 64'h6666_6666_6666_6666;
      tick();
      burst_resp  = 1'b0;
      burst_rdata = '0;
      rst         = 1'b1;
      line_read   = 1'b0;
      tick();
      chk("t4_read_drop",  LW'(burst_read), '0);
      chk("t4_no_resp",    LW'(line_resp),  '0);
      chk("t4_state",      LW'(dut.state),  LW'(ST_IDLE));
      chk("t4_rdata_zero", line_rdata,      '0);
      rst = 1'b0;
      tick();
      chk("t4_no_resp_after", LW'(line_resp), '0);
      line_read = 1'b1;
      line_addr = 32'h0000_9FFF;
      tick();
      chk("t4_re_addr", LW'(burst_addr), LW'(32'h0000_9FE0));
      chk("t4_re_read", LW'(burst_read), LW'(1'b1));
      for (int i = 0; i < 4; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = rd2[i];
         tick();
      end
      burst_resp  = 1'b0;
      burst_rdata = '0;
      chk("t4_re_resp",  LW'(line_resp), LW'(1'b1));
      chk("t4_re_rdata", line_rdata,     rd2_line);

      // Test 6: request held one cycle too long is accepted again
      tick();                                   // DONE -> IDLE
      chk("t6_done_exit", LW'(line_resp), '0);
      tick();                                   // IDLE sees the stale request
      chk("t6_reaccept_read",  LW'(burst_read), LW'(1'b1));
      chk("t6_reaccept_state", LW'(dut.state),  LW'(ST_READ));
      line_read = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
